// File: rtl/seg_frame_capture.sv
// Loop-back monitor for a multiplexed four-digit seven-segment bus: waits for each digit dwell
// to settle, decodes the glyph and publishes a coherent frame once all four digits are seen.
module seg_frame_capture #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] an,
  input  logic [6:0] out_seg,
  input  logic       dp,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] dig_err,
  output logic [3:0] dp_out,
  output logic       frame_stb,
  output logic       stale
);

  localparam int unsigned CntW  = $clog2(SETTLE + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0]  SettleMax = CntW'(SETTLE);
  localparam logic [CntW-1:0]  SettleM1  = CntW'(SETTLE - 1);
  localparam logic [IdleW-1:0] IdleMax   = IdleW'(TIMEOUT);

  logic [3:0]       s_an_q, s_an_d;
  logic [6:0]       s_seg_q, s_seg_d;
  logic             s_dp_q, s_dp_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       err_sh_q, err_sh_d;
  logic [3:0]       dp_sh_q, dp_sh_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       dig_err_q, dig_err_d;
  logic [3:0]       dp_out_q, dp_out_d;
  logic             frame_stb_q, frame_stb_d;

  logic       sel_valid, changed, capture, publish;
  logic [3:0] sel_oh;
  logic [4:0] dec;

  // Returns {illegal, value}; anything outside the sixteen glyphs decodes to 0 with the flag set.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0a;
      7'h03:   r = 5'h0b;
      7'h46:   r = 5'h0c;
      7'h21:   r = 5'h0d;
      7'h06:   r = 5'h0e;
      7'h0e:   r = 5'h0f;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    s_an_d    = an;
    s_seg_d   = out_seg;
    s_dp_d    = dp;
    sel_valid = $onehot(~an);
    changed   = {an, out_seg, dp} != {s_an_q, s_seg_q, s_dp_q};
    if (changed || !sel_valid) begin
      cnt_d = '0;
    end else if (cnt_q != SettleMax) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    // Only the SETTLE-1 -> SETTLE step captures, so a long dwell is taken once.
    capture = !changed && sel_valid && (cnt_q == SettleM1);
    sel_oh  = ~s_an_q;
    dec     = decode(s_seg_q);
  end

  always_comb begin
    shadow_d    = shadow_q;
    err_sh_d    = err_sh_q;
    dp_sh_d     = dp_sh_q;
    seen_d      = seen_q;
    publish     = 1'b0;
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_oh[i]) begin
          shadow_d[i] = dec[3:0];
          err_sh_d[i] = dec[4];
          dp_sh_d[i]  = ~s_dp_q;
        end
      end
      seen_d = seen_q | sel_oh;
      if (seen_d == 4'hf) begin
        publish = 1'b1;
        seen_d  = '0;
      end
    end
    dig_d       = publish ? shadow_d : dig_q;
    dig_err_d   = publish ? err_sh_d : dig_err_q;
    dp_out_d    = publish ? dp_sh_d : dp_out_q;
    frame_stb_d = publish;
    if (capture) begin
      idle_d = '0;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_an_q      <= '1;
      s_seg_q     <= '0;
      s_dp_q      <= 1'b0;
      cnt_q       <= '0;
      idle_q      <= '0;
      seen_q      <= '0;
      shadow_q    <= '0;
      err_sh_q    <= '0;
      dp_sh_q     <= '0;
      dig_q       <= '0;
      dig_err_q   <= '0;
      dp_out_q    <= '0;
      frame_stb_q <= 1'b0;
    end else begin
      s_an_q      <= s_an_d;
      s_seg_q     <= s_seg_d;
      s_dp_q      <= s_dp_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      seen_q      <= seen_d;
      shadow_q    <= shadow_d;
      err_sh_q    <= err_sh_d;
      dp_sh_q     <= dp_sh_d;
      dig_q       <= dig_d;
      dig_err_q   <= dig_err_d;
      dp_out_q    <= dp_out_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  assign dig3      = dig_q[3];
  assign dig2      = dig_q[2];
  assign dig1      = dig_q[1];
  assign dig0      = dig_q[0];
  assign dig_err   = dig_err_q;
  assign dp_out    = dp_out_q;
  assign frame_stb = frame_stb_q;
  assign stale     = (idle_q == IdleMax);

endmodule

// File: tb/tb_seg_frame_capture.sv
// Directed bench for seg_frame_capture: table of digit dwells plus hand-timed latency,
// stale-timeout and reset sequences.
module tb_seg_frame_capture;

  logic       clk;
  logic       reset_n;
  logic [3:0] an;
  logic [6:0] out_seg;
  logic       dp;
  logic [3:0] dig3, dig2, dig1, dig0;
  logic [3:0] dig_err;
  logic [3:0] dp_out;
  logic       frame_stb;
  logic       stale;

  int n_tests = 0;
  int n_fail  = 0;

  seg_frame_capture #(
    .SETTLE (4),
    .TIMEOUT(100)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .an       (an),
    .out_seg  (out_seg),
    .dp       (dp),
    .dig3     (dig3),
    .dig2     (dig2),
    .dig1     (dig1),
    .dig0     (dig0),
    .dig_err  (dig_err),
    .dp_out   (dp_out),
    .frame_stb(frame_stb),
    .stale    (stale)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int          hold;
    int          exp_stb;
    logic [15:0] exp_dig;
    logic [3:0]  exp_err;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one dwell for 'hold' edges, counting strobes seen at each negedge.
  task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic d, input int hold,
                       output int stbs);
    an = a;
    out_seg = s;
    dp = d;
    stbs = 0;
    repeat (hold) begin
      @(negedge clk);
      if (frame_stb) stbs++;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] frame();
    return {dig3, dig2, dig1, dig0};
  endfunction

  initial begin
    int stbs;
    int tot;

    // Frame 3,2,1,8
    tbl.push_back('{4'he, 7'h00, 1'b1, 8, 0, 16'h0000, 4'h0, 4'h0});
    tbl.push_back('{4'hd, 7'h79, 1'b1, 8, 0, 16'h0000, 4'h0, 4'h0});
    tbl.push_back('{4'hb, 7'h24, 1'b1, 8, 0, 16'h0000, 4'h0, 4'h0});
    tbl.push_back('{4'h7, 7'h30, 1'b1, 8, 1, 16'h3218, 4'h0, 4'h0});
    // Short dig1 dwell never captured, then a 5-cycle dwell completes 7,6,5,4
    tbl.push_back('{4'he, 7'h19, 1'b1, 8, 0, 16'h3218, 4'h0, 4'h0});
    tbl.push_back('{4'hd, 7'h12, 1'b1, 3, 0, 16'h3218, 4'h0, 4'h0});
    tbl.push_back('{4'hb, 7'h02, 1'b1, 8, 0, 16'h3218, 4'h0, 4'h0});
    tbl.push_back('{4'h7, 7'h78, 1'b1, 8, 0, 16'h3218, 4'h0, 4'h0});
    tbl.push_back('{4'hd, 7'h12, 1'b1, 5, 0, 16'h7654, 4'h0, 4'h0});
    tbl.push_back('{4'hf, 7'h7f, 1'b1, 2, 1, 16'h7654, 4'h0, 4'h0});
    // dig0 written 5 then 7; illegal glyph with dp on dig2
    tbl.push_back('{4'he, 7'h12, 1'b1, 8, 0, 16'h7654, 4'h0, 4'h0});
    tbl.push_back('{4'he, 7'h78, 1'b1, 8, 0, 16'h7654, 4'h0, 4'h0});
    tbl.push_back('{4'hd, 7'h0e, 1'b1, 8, 0, 16'h7654, 4'h0, 4'h0});
    tbl.push_back('{4'hb, 7'h55, 1'b0, 8, 0, 16'h7654, 4'h0, 4'h0});
    tbl.push_back('{4'h7, 7'h08, 1'b1, 8, 1, 16'ha0f7, 4'h4, 4'h4});
    // Remaining letter glyphs
    tbl.push_back('{4'he, 7'h03, 1'b1, 8, 0, 16'ha0f7, 4'h4, 4'h4});
    tbl.push_back('{4'hd, 7'h46, 1'b1, 8, 0, 16'ha0f7, 4'h4, 4'h4});
    tbl.push_back('{4'hb, 7'h21, 1'b1, 8, 0, 16'ha0f7, 4'h4, 4'h4});
    tbl.push_back('{4'h7, 7'h06, 1'b1, 8, 1, 16'hedcb, 4'h0, 4'h0});

    reset_n = 1'b0;
    an = 4'hf;
    out_seg = 7'h7f;
    dp = 1'b1;
    #3;
    chk("reset_dig", 32'(frame()), 32'h0);
    chk("reset_flags", {24'h0, dig_err, dp_out}, 32'h0);
    chk("reset_stb_stale", {30'h0, frame_stb, stale}, 32'h0);
    #9;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].hold, stbs);
      chk($sformatf("step%0d_stb", i), 32'(stbs), 32'(tbl[i].exp_stb));
      chk($sformatf("step%0d_dig", i), 32'(frame()), 32'(tbl[i].exp_dig));
      chk($sformatf("step%0d_err", i), 32'(dig_err), 32'(tbl[i].exp_err));
      chk($sformatf("step%0d_dp", i), 32'(dp_out), 32'(tbl[i].exp_dp));
    end

    // Strobe latency: frame 9,2,1,0 with the last dwell timed by hand.
    tot = 0;
    apply(4'he, 7'h40, 1'b1, 8, stbs); tot += stbs;
    apply(4'hd, 7'h79, 1'b1, 8, stbs); tot += stbs;
    apply(4'hb, 7'h24, 1'b1, 8, stbs); tot += stbs;
    chk("lat_pre_stb", 32'(tot), 32'h0);
    an = 4'h7;
    out_seg = 7'h10;
    repeat (4) @(posedge clk);
    #1;
    chk("lat_early_stb", {31'h0, frame_stb}, 32'h0);
    @(posedge clk);
    #1;
    chk("lat_stb", {31'h0, frame_stb}, 32'h1);
    chk("lat_dig", 32'(frame()), 32'h9210);
    @(posedge clk);
    #1;
    chk("lat_stb_pulse", {31'h0, frame_stb}, 32'h0);

    // Stale after 100 idle cycles, cleared by the next capture.
    an = 4'hf;
    repeat (98) @(posedge clk);
    #1;
    chk("stale_99", {31'h0, stale}, 32'h0);
    @(posedge clk);
    #1;
    chk("stale_100", {31'h0, stale}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("stale_sat", {31'h0, stale}, 32'h1);
    an = 4'he;
    out_seg = 7'h40;
    repeat (4) @(posedge clk);
    #1;
    chk("stale_pre_cap", {31'h0, stale}, 32'h1);
    @(posedge clk);
    #1;
    chk("stale_cleared", {31'h0, stale}, 32'h0);

    // Capture lands on the edge where idle would reach TIMEOUT.
    an = 4'hf;
    repeat (95) @(posedge clk);
    #1;
    an = 4'hd;
    out_seg = 7'h79;
    repeat (4) @(posedge clk);
    #1;
    chk("race_idle99", {31'h0, stale}, 32'h0);
    @(posedge clk);
    #1;
    chk("race_cap_edge", {31'h0, stale}, 32'h0);
    @(posedge clk);
    #1;
    chk("race_after", {31'h0, stale}, 32'h0);

    // Asynchronous reset with dig0/dig1 pending; they must not count afterwards.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_dig", 32'(frame()), 32'h0);
    chk("arst_flags", {24'h0, dig_err, dp_out}, 32'h0);
    chk("arst_stb_stale", {30'h0, frame_stb, stale}, 32'h0);
    an = 4'hf;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tot = 0;
    apply(4'hb, 7'h02, 1'b1, 8, stbs); tot += stbs;
    apply(4'h7, 7'h78, 1'b1, 8, stbs); tot += stbs;
    chk("post_rst_partial_stb", 32'(tot), 32'h0);
    chk("post_rst_partial_dig", 32'(frame()), 32'h0);
    tot = 0;
    apply(4'he, 7'h19, 1'b1, 8, stbs); tot += stbs;
    apply(4'hd, 7'h12, 1'b1, 8, stbs); tot += stbs;
    chk("post_rst_stb", 32'(tot), 32'h1);
    chk("post_rst_dig", 32'(frame()), 32'h7654);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
